// File: rtl/io_input_port_ctrl.sv
// Input-side I/O peripheral: synchronises and debounces switches and active-low keys,
// latches key presses, exposes memory-mapped read registers. Optional IRQ via IO_IN_IRQ_EN.
module io_input_port_ctrl #(
  parameter int         DEBOUNCE_CYCLES = 250000,
  parameter int         CNT_W           = 18,
  parameter logic [7:0] BASE_ADDR       = 8'h80
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [9:0]  sw,
  input  logic [3:1]  key,
  input  logic [7:0]  io_addr,
  input  logic        io_rd,
`ifdef IO_IN_IRQ_EN
  input  logic        io_wr,
  input  logic [3:1]  io_wdata,
  output logic        irq,
`endif
  output logic [31:0] io_read_data,
  output logic [31:0] in_port0,
  output logic [31:0] in_port1
);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [9:0]       sw_meta, sw_sync, sw_samp, sw_db, sw_db_next;
  logic [3:1]       key_meta, key_sync, key_samp, key_db, key_db_next;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic [3:1]       press_rise, evt, evt_next;
  logic [15:0]      press_cnt, press_inc;
  logic [7:0]       offset;
  logic             rd_evt;
  logic [31:0]      rd_sel;
`ifdef IO_IN_IRQ_EN
  logic [3:1]       mask;
`endif

  // Keys idle high, so their synchroniser and debounce state reset to released.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      key_meta <= '1;
      key_sync <= '1;
    end else begin
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
      key_meta <= key;
      key_sync <= key_meta;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  // A bit is accepted only when two consecutive tick samples agree.
  always_comb begin
    sw_db_next  = sw_db;
    key_db_next = key_db;
    if (tick) begin
      sw_db_next  = (~(sw_sync ^ sw_samp) & sw_sync) | ((sw_sync ^ sw_samp) & sw_db);
      key_db_next = (~(key_sync ^ key_samp) & key_sync) | ((key_sync ^ key_samp) & key_db);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sw_samp  <= '0;
      sw_db    <= '0;
      key_samp <= '1;
      key_db   <= '1;
    end else if (tick) begin
      sw_samp  <= sw_sync;
      sw_db    <= sw_db_next;
      key_samp <= key_sync;
      key_db   <= key_db_next;
    end
  end

  assign press_rise = key_db & ~key_db_next;
  assign press_inc  = 16'(press_rise[1]) + 16'(press_rise[2]) + 16'(press_rise[3]);
  assign offset     = io_addr - BASE_ADDR;
  assign rd_evt     = io_rd && (offset == 8'h08);
  // An EVT read clears exactly what it returned; a press in the same cycle still lands.
  assign evt_next   = rd_evt ? press_rise : (evt | press_rise);

  always_comb begin
    rd_sel = 32'h0;
    case (offset)
      8'h00: rd_sel = {22'b0, sw_db};
      8'h04: rd_sel = {28'b0, ~key_db, 1'b0};
      8'h08: rd_sel = {28'b0, evt, 1'b0};
      8'h0C: rd_sel = {16'b0, press_cnt};
`ifdef IO_IN_IRQ_EN
      8'h10: rd_sel = {28'b0, mask, 1'b0};
`endif
      default: rd_sel = 32'h0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      evt          <= '0;
      press_cnt    <= '0;
      io_read_data <= '0;
    end else begin
      evt       <= evt_next;
      press_cnt <= press_cnt + press_inc;
      if (io_rd) begin
        io_read_data <= rd_sel;
      end
    end
  end

`ifdef IO_IN_IRQ_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mask <= 3'b111;
      irq  <= 1'b0;
    end else begin
      irq <= |(evt & mask);
      if (io_wr && (offset == 8'h10)) begin
        mask <= io_wdata;
      end
    end
  end
`endif

  assign in_port0 = {22'b0, sw_db};
  assign in_port1 = {28'b0, ~key_db, 1'b0};

endmodule

// File: tb/tb_io_input_port_ctrl.sv
// Self-checking bench for io_input_port_ctrl with DEBOUNCE_CYCLES=4; a cycle-level
// behavioural model is compared every cycle, plus directed literal expectations.
module tb_io_input_port_ctrl;

  localparam int         DB   = 4;
  localparam logic [7:0] BASE = 8'h80;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [9:0]  sw = '0;
  logic [3:1]  key = 3'b111;
  logic [7:0]  io_addr = 8'h00;
  logic        io_rd = 1'b0;
  logic [31:0] io_read_data, in_port0, in_port1;
`ifdef IO_IN_IRQ_EN
  logic        io_wr = 1'b0;
  logic [3:1]  io_wdata = 3'b000;
  logic        irq;
`endif

  int total = 0;
  int bad = 0;

  io_input_port_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(3), .BASE_ADDR(BASE)) dut (
    .clock(clock), .resetn(resetn), .sw(sw), .key(key),
    .io_addr(io_addr), .io_rd(io_rd),
`ifdef IO_IN_IRQ_EN
    .io_wr(io_wr), .io_wdata(io_wdata), .irq(irq),
`endif
    .io_read_data(io_read_data), .in_port0(in_port0), .in_port1(in_port1)
  );

  always #5 clock = ~clock;

  // Model state: raw inputs delayed two clocks, sampled on every DB-th clock,
  // accepted when two successive samples agree.
  logic [9:0]  sw_p1, sw_p2, m_samp_sw, m_db_sw, new_db_sw;
  logic [3:1]  key_p1, key_p2, m_samp_key, m_db_key, new_db_key;
  logic [3:1]  m_evt, m_mask, m_pend, rise;
  logic [15:0] m_cnt;
  logic [31:0] m_rdata;
  logic        m_irq;
  logic [7:0]  m_off;
  int          m_cyc;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] reg_value(input logic [7:0] off);
    case (off)
      8'h00: return {22'b0, m_db_sw};
      8'h04: return {28'b0, ~m_db_key, 1'b0};
      8'h08: return {28'b0, m_evt, 1'b0};
      8'h0C: return {16'b0, m_cnt};
`ifdef IO_IN_IRQ_EN
      8'h10: return {28'b0, m_mask, 1'b0};
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    sw_p1 = '0; sw_p2 = '0; m_samp_sw = '0; m_db_sw = '0;
    key_p1 = '1; key_p2 = '1; m_samp_key = '1; m_db_key = '1;
    m_evt = '0; m_mask = 3'b111; m_pend = '0; m_cnt = '0;
    m_rdata = '0; m_irq = 1'b0; m_cyc = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or negedge resetn);
      if (!resetn) begin
        model_reset();
      end else begin
        m_off = io_addr - BASE;
        if (io_rd) m_rdata = reg_value(m_off);
        m_irq = |(m_evt & m_mask);
        new_db_sw = m_db_sw;
        new_db_key = m_db_key;
        if ((m_cyc % DB) == DB - 1) begin
          for (int i = 0; i < 10; i++)
            if (sw_p2[i] == m_samp_sw[i]) new_db_sw[i] = sw_p2[i];
          for (int k = 1; k <= 3; k++)
            if (key_p2[k] == m_samp_key[k]) new_db_key[k] = key_p2[k];
          m_samp_sw = sw_p2;
          m_samp_key = key_p2;
        end
        rise = m_db_key & ~new_db_key;
        if (io_rd && m_off == 8'h08) m_evt = '0;
        m_evt = m_evt | rise;
        m_cnt = m_cnt + 16'($countones(rise));
        m_db_sw = new_db_sw;
        m_db_key = new_db_key;
`ifdef IO_IN_IRQ_EN
        if (io_wr && m_off == 8'h10) m_mask = io_wdata;
`endif
        sw_p2 = sw_p1; sw_p1 = sw;
        key_p2 = key_p1; key_p1 = key;
        m_cyc++;
        m_pend = '0;
        if ((m_cyc % DB) == DB - 1)
          for (int k = 1; k <= 3; k++)
            m_pend[k] = m_db_key[k] & (key_p2[k] == m_samp_key[k]) & ~key_p2[k];
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      check32("in_port0", in_port0, {22'b0, m_db_sw});
      check32("in_port1", in_port1, {28'b0, ~m_db_key, 1'b0});
      check32("io_read_data", io_read_data, m_rdata);
`ifdef IO_IN_IRQ_EN
      check32("irq", {31'b0, irq}, {31'b0, m_irq});
`endif
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic do_read(input logic [7:0] off, input logic [31:0] exp, input string name);
    @(negedge clock);
    io_addr = BASE + off;
    io_rd = 1'b1;
    @(negedge clock);
    io_rd = 1'b0;
    check32(name, io_read_data, exp);
  endtask

  task automatic applyStimulus();
    bit found;
    // Reset state
    wait_cycles(2);
    check32("rst_in_port0", in_port0, 32'h0);
    check32("rst_in_port1", in_port1, 32'h0);
    check32("rst_rdata", io_read_data, 32'h0);
    @(negedge clock);
    resetn = 1'b1;

    // Switch pattern reaches in_port0 and SW register
    sw = 10'b1000100100;
    wait_cycles(20);
    check32("sw_in_port0", in_port0, 32'h224);
    do_read(8'h00, 32'h224, "sw_read");

    // Short glitch on key[2] is rejected
    @(negedge clock);
    key = 3'b101;
    wait_cycles(3);
    key = 3'b111;
    wait_cycles(20);
    check32("glitch_in_port1", in_port1, 32'h0);
    do_read(8'h08, 32'h0, "glitch_evt");
    do_read(8'h0C, 32'h0, "glitch_cnt");

    // key[1] press, EVT read-to-clear, counter
    key = 3'b110;
    wait_cycles(20);
    check32("k1_in_port1", in_port1, 32'h2);
    do_read(8'h08, 32'h2, "k1_evt_first");
    do_read(8'h08, 32'h0, "k1_evt_second");
    do_read(8'h0C, 32'h1, "k1_cnt");
    do_read(8'h14, 32'h0, "unmapped");
    key = 3'b111;
    wait_cycles(20);

    // Simultaneous presses, then a press landing on the EVT-clear cycle
    pulse_reset();
    key = 3'b001;
    wait_cycles(20);
    check32("k32_in_port1", in_port1, 32'hC);
    key = 3'b011;
    wait_cycles(20);
    key = 3'b001;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clock);
      if (m_pend[2]) found = 1'b1;
    end
    check32("pend_seen", {31'b0, found}, 32'h1);
    io_addr = BASE + 8'h08;
    io_rd = 1'b1;
    @(negedge clock);
    io_rd = 1'b0;
    check32("collide_evt_read", io_read_data, 32'hC);
    check32("model_evt_after", {29'b0, m_evt}, 32'h2);
    do_read(8'h08, 32'h4, "set_wins_evt");
    do_read(8'h0C, 32'h3, "collide_cnt");
    key = 3'b111;
    wait_cycles(20);

    // Reset during a partial debounce of key[1]
    key = 3'b110;
    wait_cycles(6);
    check32("partial_in_port1", in_port1, 32'h0);
    resetn = 1'b0;
    key = 3'b111;
    @(negedge clock);
    check32("midrst_in_port0", in_port0, 32'h0);
    check32("midrst_in_port1", in_port1, 32'h0);
    check32("midrst_rdata", io_read_data, 32'h0);
    resetn = 1'b1;
    wait_cycles(20);
    do_read(8'h08, 32'h0, "postrst_evt");
    do_read(8'h0C, 32'h0, "postrst_cnt");

`ifdef IO_IN_IRQ_EN
    // Interrupt timing and masking
    pulse_reset();
    key = 3'b110;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clock);
      if (m_evt[1]) found = 1'b1;
    end
    check32("evt_seen", {31'b0, found}, 32'h1);
    check32("irq_not_yet", {31'b0, irq}, 32'h0);
    @(negedge clock);
    check32("irq_rise", {31'b0, irq}, 32'h1);
    io_addr = BASE + 8'h10;
    io_wdata = 3'b000;
    io_wr = 1'b1;
    @(negedge clock);
    io_wr = 1'b0;
    @(negedge clock);
    check32("irq_masked", {31'b0, irq}, 32'h0);
    do_read(8'h10, 32'h0, "mask_read");
    do_read(8'h08, 32'h2, "irq_evt_read");
    wait_cycles(2);
    check32("irq_stays_low", {31'b0, irq}, 32'h0);
    key = 3'b111;
`endif
    wait_cycles(4);
  endtask

  initial begin
    applyStimulus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_input_port_ctrl.md
Name: io_input_port_ctrl

Overview:
- Input-side I/O peripheral of the single-cycle computer.
- Synchronises and debounces board switches sw[9:0] and push-buttons key[3:1], which are active-low.
- Latches key-press events and presents everything to the CPU as memory-mapped read registers, plus direct in_port0/in_port1 buses.
- Counterpart of the output-port/hex-display path: the CPU reads through this block what the board or bench drives.

Parameters:
- DEBOUNCE_CYCLES, 250000: clock cycles per debounce sample tick; must be ≥ 2. Benches use 4.
- CNT_W, 18: width of the tick counter; must hold DEBOUNCE_CYCLES-1.
- BASE_ADDR, 8'h80: byte address of register 0; the low 2 bits are 0.

Ports:
- clock  in  1  system clock; everything is posedge.
- resetn  in  1  asynchronous, active-low reset.
- sw  in  10  raw slide switches; asynchronous to clock.
- key  in  3  raw push-buttons, bits [3:1]; 0 = pressed; asynchronous to clock.
- io_addr  in  8  CPU byte address, low byte.
- io_rd  in  1  CPU read strobe, one cycle per access.
- io_read_data  out  32  registered read data.
- in_port0  out  32  {22'b0, debounced sw}.
- in_port1  out  32  {28'b0, pressed[3:1], 1'b0}, where pressed = ~debounced key.
- irq  out  1  present only with IO_IN_IRQ_EN.

Behaviour:
- Reset (asynchronous, resetn=0):
  - Sync stages, sample register and debounced value: sw bits 0, key bits 1.
  - Tick counter 0; evt 0; press_cnt 0; io_read_data 0.
  - Therefore in_port0=0, in_port1=0, irq=0.
- Synchroniser:
  - 2-flop chain per bit; sync = second stage.
  - Latency from a raw input change to sync is 2 clocks.
- Tick counter:
  - Counts 0..DEBOUNCE_CYCLES-1, then wraps to 0.
  - tick=1 in the cycle the count equals DEBOUNCE_CYCLES-1.
- Debounce (per bit i, on tick):
  - If sync[i]==sample[i], then db[i] <= sync[i].
  - Always sample[i] <= sync[i].
  - A change is accepted only after two consecutive agreeing ticks; a glitch shorter than one tick period never reaches db.
  - Latency from a stable raw change to db is between DEBOUNCE_CYCLES+3 and 2*DEBOUNCE_CYCLES+3 clocks.
- Key events:
  - pressed[k] = ~db_key[k].
  - A 0->1 transition of pressed[k] sets evt[k]; it stays set (sticky) until cleared.
  - Each press (any key, simultaneous presses counted individually) increments press_cnt (16-bit, wraps FFFF->0000).
- Register map (word offset from BASE_ADDR):
  - +0 SW: {22'b0, db_sw}
  - +4 KEY: {28'b0, pressed, 1'b0}
  - +8 EVT: {28'b0, evt, 1'b0}; read-to-clear
  - +C CNT: {16'b0, press_cnt}
  - Any other address: 32'h0.
- Read timing:
  - When io_rd=1, io_read_data <= the selected register in the next clock edge; 1-cycle latency.
  - When io_rd=0, io_read_data holds its previous value.
- EVT read:
  - Returns the pre-clear value and clears only the bits it returned.
  - If a new press of key k occurs in the same cycle as the clear, evt[k] ends at 1: set wins.
- in_port0 and in_port1 are continuous views of db and pressed; no extra latency beyond db.
- A reset asserted mid-debounce discards partial samples. After release, keys read as released, so no spurious event is generated.

Optional Feature:
- Macro: IO_IN_IRQ_EN.
- Defined:
  - Port irq exists; irq is registered as |evt.
  - irq rises 1 clock after an evt bit sets and falls 1 clock after the EVT read that empties evt.
  - An extra register +10 IRQ_MASK (3 bits, reset 3'b111) is added, with write port io_wr plus io_wdata[3:1]; irq = |(evt & mask).
- Undefined:
  - No irq, io_wr or io_wdata ports exist; offset +10 reads 0.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset, then sw=10'b1000100100 held 20 clocks -> in_port0=32'h224; a read of +0 returns 32'h224 one clock after io_rd.
2. key[2] pulled low for 3 clocks only, then released -> db unchanged, in_port1=0, evt=0, press_cnt=0.
3. key[1] held low 20 clocks -> in_port1=32'h2; read +8 returns 32'h2; a second read of +8 returns 0; read +C returns 1.
4. key[3] and key[2] pressed simultaneously, and key[2] pressed again while an EVT read is in flight -> the EVT read returns 32'hC; afterwards evt[2]=1 (set wins); press_cnt=3.
5. resetn pulsed low while key[1] is held and its debounce is partial -> all outputs 0 during reset. After release, with key[1] released, no event is generated and press_cnt=0.
6. With IO_IN_IRQ_EN: key[1] press -> irq=1 one clock after evt sets. Write mask 3'b000 -> irq=0. EVT read -> evt clears and irq stays 0.
